// File: rtl/bcd_serial_adder_if.sv
// rtl/bcd_serial_adder_if.sv - operand/result handshake bundle for the serial BCD adder
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  Cin;
    logic                  Sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   S;
    logic                  Cout;
    logic                  Err;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Err
    );

    // The adder itself
    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Err
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial packed-BCD adder/subtractor with valid/ready handshake
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_serial_adder_if.slave  bus
);
    localparam int W    = 4 * DIGITS;
    localparam int CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic            bad_q, bad_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [W-1:0]    b_nines;
    logic            raw_bad;
    logic [4:0]      sum;
    logic [3:0]      digit;
    logic            carry_nx;
    logic [W-1:0]    res_shift;

    // Operand pre-processing: nines complement of B and invalid-nibble detection on raw inputs
    always_comb begin
        b_nines = '0;
        raw_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            b_nines[4*k +: 4] = 4'd9 - bus.B[4*k +: 4];
            if ((bus.A[4*k +: 4] > 4'd9) || (bus.B[4*k +: 4] > 4'd9)) begin
                raw_bad = 1'b1;
            end
        end
    end

    // Single digit-adder slice with decimal correction; new digit enters the result from the top
    always_comb begin
        sum      = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        digit    = sum[3:0];
        carry_nx = 1'b0;
        if (sum > 5'd9) begin
            digit    = 4'(sum - 5'd10);
            carry_nx = 1'b1;
        end
        res_shift = (res_q >> 4) | (W'(digit) << (4 * (DIGITS - 1)));
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        bad_d       = bad_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        cout_d      = cout_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.A;
                    b_d        = bus.Sub ? b_nines : bus.B;
                    carry_d    = bus.Cin ^ bus.Sub;
                    bad_d      = raw_bad;
                    res_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                in_ready_d = 1'b0;
                a_d        = a_q >> 4;
                b_d        = b_q >> 4;
                res_d      = res_shift;
                carry_d    = carry_nx;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    s_d         = bad_q ? '0 : res_shift;
                    cout_d      = bad_q ? 1'b0 : carry_nx;
                    err_d       = bad_q;
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything including in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            bad_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            bad_q       <= bad_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.Err       = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - randomized and directed bench for bcd_serial_adder
module tb_bcd_serial_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_serial_adder_if #(.DIGITS(4)) i4 ();
    bcd_serial_adder_if #(.DIGITS(1)) i1 ();

    bcd_serial_adder #(.DIGITS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    bcd_serial_adder #(.DIGITS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decode BCD to integers, do decimal arithmetic, re-encode
    function automatic void model(input int nd, input logic [63:0] a, input logic [63:0] b,
                                  input bit cin, input bit sub,
                                  output logic [63:0] s, output bit cout, output bit err);
        longint av, bv, m, r, ci;
        av = 0; bv = 0; m = 1; err = 1'b0; s = '0;
        ci = longint'(cin);
        for (int k = nd - 1; k >= 0; k--) begin
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) err = 1'b1;
            av = av * 10 + longint'(a[4*k +: 4]);
            bv = bv * 10 + longint'(b[4*k +: 4]);
            m  = m * 10;
        end
        if (err) begin
            cout = 1'b0;
            return;
        end
        if (sub) begin
            r    = av - bv - ci;
            cout = (r >= 0);
        end else begin
            r    = av + bv + ci;
            cout = (r >= m);
        end
        if (r < 0) r = r + m;
        else if (r >= m) r = r - m;
        for (int k = 0; k < nd; k++) begin
            s[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    function automatic logic [15:0] rand_bcd4(input bit allow_bad);
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 7) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    task automatic run4(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                        input int hold, input bit noise);
        logic [63:0] es;
        bit          ec, ee;
        int          n;
        model(4, {48'd0, a}, {48'd0, b}, cin, sub, es, ec, ee);
        n = 0;
        while (!i4.in_ready && n < 10) begin @(posedge clk); #1; n++; end
        chk("d4_in_ready_idle", i4.in_ready, 1);
        i4.in_valid = 1'b1; i4.A = a; i4.B = b; i4.Cin = cin; i4.Sub = sub;
        @(posedge clk); #1;
        i4.in_valid = 1'b0;
        chk("d4_in_ready_busy", i4.in_ready, 0);
        n = 0;
        while (!i4.out_valid && n < 20) begin
            if (noise) begin
                i4.in_valid = 1'($urandom_range(0, 1));
                i4.A = 16'($urandom); i4.B = 16'($urandom);
                i4.Cin = 1'($urandom); i4.Sub = 1'($urandom);
            end
            @(posedge clk); #1; n++;
        end
        chk("d4_latency", n, 4);
        chk("d4_S", i4.S, es);
        chk("d4_Cout", i4.Cout, ec);
        chk("d4_Err", i4.Err, ee);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin i4.in_valid = 1'b1; i4.A = 16'($urandom); i4.B = 16'($urandom); end
            @(posedge clk); #1;
            chk("d4_hold_valid", i4.out_valid, 1);
            chk("d4_hold_S", i4.S, es);
            chk("d4_hold_Cout", i4.Cout, ec);
            chk("d4_hold_in_ready", i4.in_ready, 0);
        end
        i4.in_valid  = noise;
        i4.out_ready = 1'b1;
        @(posedge clk); #1;
        i4.out_ready = 1'b0;
        i4.in_valid  = 1'b0;
        chk("d4_release_valid", i4.out_valid, 0);
        chk("d4_release_ready", i4.in_ready, 1);
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input bit cin, input bit sub);
        logic [63:0] es;
        bit          ec, ee;
        int          n;
        model(1, {60'd0, a}, {60'd0, b}, cin, sub, es, ec, ee);
        n = 0;
        while (!i1.in_ready && n < 10) begin @(posedge clk); #1; n++; end
        i1.in_valid = 1'b1; i1.A = a; i1.B = b; i1.Cin = cin; i1.Sub = sub;
        @(posedge clk); #1;
        i1.in_valid = 1'b0;
        n = 0;
        while (!i1.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("d1_latency", n, 1);
        chk("d1_S", i1.S, es);
        chk("d1_Cout", i1.Cout, ec);
        chk("d1_Err", i1.Err, ee);
        i1.out_ready = 1'b1;
        @(posedge clk); #1;
        i1.out_ready = 1'b0;
        chk("d1_release_ready", i1.in_ready, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        i4.in_valid = 1'b0; i4.A = '0; i4.B = '0; i4.Cin = 1'b0; i4.Sub = 1'b0; i4.out_ready = 1'b0;
        i1.in_valid = 1'b0; i1.A = '0; i1.B = '0; i1.Cin = 1'b0; i1.Sub = 1'b0; i1.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", i4.in_ready, 0);
        chk("rst_out_valid", i4.out_valid, 0);
        chk("rst_S", i4.S, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready4", i4.in_ready, 1);
        chk("post_rst_in_ready1", i1.in_ready, 1);

        run4(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 1'b0);
        run4(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run4(16'h9999, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run4(16'h5000, 16'h1234, 1'b0, 1'b1, 0, 1'b0);
        run4(16'h1234, 16'h5000, 1'b0, 1'b1, 0, 1'b0);
        run4(16'h12A4, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run4(16'h0005, 16'h00B0, 1'b0, 1'b1, 0, 1'b0);
        run4(16'h0000, 16'h0000, 1'b1, 1'b1, 1, 1'b0);
        run4(16'h4321, 16'h0789, 1'b1, 1'b0, 3, 1'b1);

        for (int t = 0; t < 40; t++) begin
            run4(rand_bcd4(1'b1), rand_bcd4(1'b1), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2), 1'($urandom));
        end

        run4(16'h8765, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        i4.in_valid = 1'b1; i4.A = 16'h1234; i4.B = 16'h5678; i4.Cin = 1'b0; i4.Sub = 1'b0;
        @(posedge clk); #1;
        i4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", i4.out_valid, 0);
        chk("midrun_rst_in_ready", i4.in_ready, 0);
        chk("midrun_rst_S", i4.S, 0);
        chk("midrun_rst_Cout", i4.Cout, 0);
        chk("midrun_rst_Err", i4.Err, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrun_release_in_ready", i4.in_ready, 1);
        run4(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 1'b0);

        run1(4'h9, 4'h9, 1'b1, 1'b0);
        run1(4'h3, 4'h7, 1'b0, 1'b1);
        run1(4'hC, 4'h1, 1'b0, 1'b0);
        for (int t = 0; t < 10; t++) begin
            run1(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
